// File: rtl/data_sram_bridge.sv
// M-stage load/store to SRAM-like bridge: one request per instruction, stall until data_ok.
// Latency: 3 stall cycles best case (2 if addr_ok and data_ok coincide); waits on addr_ok/data_ok, DONE holds while pipe_stall.
module data_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        pipe_stall,
    output logic [31:0] cpu_rdata,
    output logic        stall_req,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    // Irregular multi-byte strobes fall back to a full word access.
    function automatic logic [1:0] store_size(input logic [3:0] wen);
        logic [1:0] sz;
        case (wen)
            4'b1111:                            sz = 2'd2;
            4'b0011, 4'b1100:                   sz = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
            default:                            sz = 2'd2;
        endcase
        return sz;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        data_req  = 1'b0;
        stall_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_en) begin
                    stall_req = 1'b1;
                    state_d   = ADDR;
                    wr_d      = |cpu_wen;
                    wdata_d   = cpu_wdata;
                    // Loads fetch the whole word; byte/half selection happens in W.
                    if (|cpu_wen) begin
                        size_d = store_size(cpu_wen);
                        addr_d = cpu_addr;
                    end else begin
                        size_d = 2'd2;
                        addr_d = {cpu_addr[31:2], 2'b00};
                    end
                end
            end
            ADDR: begin
                data_req  = 1'b1;
                stall_req = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = DONE;
                        if (!wr_q) rdata_d = data_rdata;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                stall_req = 1'b1;
                if (data_data_ok) begin
                    state_d = DONE;
                    if (!wr_q) rdata_d = data_rdata;
                end
            end
            DONE: begin
                if (!pipe_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_rdata  = rdata_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Scoreboard bench for data_sram_bridge: expected requests/load data queued at issue, checked at handshake/DONE.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        pipe_stall;
    logic [31:0] cpu_rdata;
    logic        stall_req;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] rdata_m;
    int          checks;
    int          errors;

    data_sram_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_en       (cpu_en),
        .cpu_wen      (cpu_wen),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .pipe_stall   (pipe_stall),
        .cpu_rdata    (cpu_rdata),
        .stall_req    (stall_req),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] size_of(input logic [3:0] wen);
        if (wen == 4'b1111) return 2'd2;
        if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
        if (wen == 4'b0001 || wen == 4'b0010 || wen == 4'b0100 || wen == 4'b1000) return 2'd0;
        return 2'd2;
    endfunction

    // One access: IDLE, addr_wait+1 ADDR cycles, data_wait+1 DATA cycles (none if same), hold+1 DONE cycles.
    task automatic drive_access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int addr_wait, input int data_wait,
                                input bit same, input int hold, output int stall_cnt, output int req_cnt);
        req_t e;
        req_t f;
        int   n_addr;
        int   n_data;
        int   n_total;
        int   ph;
        int   k;
        e.wr    = |wen;
        e.size  = e.wr ? size_of(wen) : 2'd2;
        e.addr  = e.wr ? addr : {addr[31:2], 2'b00};
        e.wdata = wdata;
        exp_q.push_back(e);
        rd_q.push_back(e.wr ? rdata_m : rdata);
        n_addr    = addr_wait + 1;
        n_data    = same ? 0 : data_wait + 1;
        n_total   = 1 + n_addr + n_data + hold + 1;
        stall_cnt = 0;
        req_cnt   = 0;
        for (int c = 0; c < n_total; c++) begin
            if (c == 0) begin
                ph = 0; k = 0;
                cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
                pipe_stall = 1'b0; data_addr_ok = 1'b0;
                data_data_ok = 1'b1; data_rdata = 32'hBAD0_0000;
            end else if (c <= n_addr) begin
                ph = 1; k = c - 1;
                cpu_wen = 4'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
                data_addr_ok = (k == addr_wait);
                data_data_ok = (k == addr_wait) && same;
                data_rdata   = data_data_ok ? rdata : $urandom;
            end else if (c <= n_addr + n_data) begin
                ph = 2; k = c - 1 - n_addr;
                data_addr_ok = 1'($urandom);
                data_data_ok = (k == data_wait);
                data_rdata   = data_data_ok ? rdata : $urandom;
            end else begin
                ph = 3; k = c - 1 - n_addr - n_data;
                pipe_stall   = (k < hold);
                cpu_en       = pipe_stall;
                data_addr_ok = 1'b1;
                data_data_ok = 1'b1;
                data_rdata   = $urandom;
            end
            @(negedge clk);
            if (stall_req) stall_cnt++;
            checks++;
            if (data_req !== (ph == 1)) begin
                errors++;
                $display("FAIL data_req phase %0d cycle %0d got %b want %b", ph, c, data_req, ph == 1);
            end
            checks++;
            if (stall_req !== (ph != 3)) begin
                errors++;
                $display("FAIL stall_req phase %0d cycle %0d got %b want %b", ph, c, stall_req, ph != 3);
            end
            if (ph == 1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_fields no expected request queued");
                end else begin
                    f = exp_q[0];
                    checks++;
                    if ({data_wr, data_size, data_addr, data_wdata} !== {f.wr, f.size, f.addr, f.wdata}) begin
                        errors++;
                        $display("FAIL req_fields got wr %b size %0d addr %h wdata %h want wr %b size %0d addr %h wdata %h",
                                 data_wr, data_size, data_addr, data_wdata, f.wr, f.size, f.addr, f.wdata);
                    end
                    if (data_req && data_addr_ok) begin
                        req_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (ph == 3) begin
                if (k == 0 && rd_q.size() != 0) rdata_m = rd_q.pop_front();
                checks++;
                if (cpu_rdata !== rdata_m) begin
                    errors++;
                    $display("FAIL cpu_rdata done cycle %0d got %h want %h", k, cpu_rdata, rdata_m);
                end
            end
            @(posedge clk);
            #1;
        end
        cpu_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; pipe_stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_en = 1'b0; cpu_wen = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        pipe_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        rdata_m = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({data_req, stall_req, cpu_rdata, data_wr, data_size, data_addr, data_wdata} !== 101'd0) begin
            errors++;
            $display("FAIL reset_outputs req %b stall %b rdata %h wr %b size %0d addr %h wdata %h want all zero",
                     data_req, stall_req, cpu_rdata, data_wr, data_size, data_addr, data_wdata);
        end
        cpu_en = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b1 || data_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_cpu_en got stall %b req %b want stall 1 req 0", stall_req, data_req);
        end
        cpu_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_load();
        int s, r;
        drive_access(4'b0000, 32'h1000_0006, 32'h1111_2222, 32'hDEAD_BEEF, 0, 0, 1'b0, 0, s, r);
        checks++;
        if (s !== 3 || r !== 1) begin
            errors++;
            $display("FAIL load_stall got stall %0d reqs %0d want stall 3 reqs 1", s, r);
        end
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 32'hDEAD_BEEF || stall_req !== 1'b0 || data_req !== 1'b0) begin
            errors++;
            $display("FAIL load_idle got rdata %h stall %b req %b want deadbeef 0 0", cpu_rdata, stall_req, data_req);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_byte();
        int s, r;
        drive_access(4'b0100, 32'h0000_0020, 32'h5A5A_5A5A, 32'h0BAD_BAD0, 0, 0, 1'b0, 0, s, r);
        checks++;
        if (s !== 3 || r !== 1 || cpu_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_byte got stall %0d reqs %0d rdata %h want 3 1 deadbeef", s, r, cpu_rdata);
        end
    endtask

    task automatic test_store_sizes();
        logic [3:0] wens [7];
        int s, r;
        wens = '{4'b0011, 4'b1100, 4'b1111, 4'b0110, 4'b1000, 4'b0001, 4'b1010};
        foreach (wens[i]) begin
            drive_access(wens[i], 32'h0000_0100 + 32'(i), $urandom, $urandom, i % 2, 0, 1'b0, 0, s, r);
            checks++;
            if (r !== 1) begin
                errors++;
                $display("FAIL store_size_reqs wen %b got %0d want 1", wens[i], r);
            end
        end
    endtask

    task automatic test_backpressure();
        int s, r;
        drive_access(4'b0000, 32'h0000_0107, 32'h0, 32'h0102_0304, 3, 1, 1'b0, 0, s, r);
        checks++;
        if (s !== 7 || r !== 1) begin
            errors++;
            $display("FAIL backpressure got stall %0d reqs %0d want 7 1", s, r);
        end
    endtask

    task automatic test_hold();
        int s, r;
        drive_access(4'b0000, 32'h0000_0200, 32'h0, 32'h1234_5678, 0, 0, 1'b0, 3, s, r);
        checks++;
        if (s !== 3 || cpu_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL hold got stall %0d rdata %h want 3 12345678", s, cpu_rdata);
        end
    endtask

    task automatic test_same_cycle();
        int s, r;
        drive_access(4'b0000, 32'h0000_0300, 32'h0, 32'hCAFE_0001, 0, 0, 1'b1, 0, s, r);
        checks++;
        if (s !== 2 || r !== 1 || cpu_rdata !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL same_cycle got stall %0d reqs %0d rdata %h want 2 1 cafe0001", s, r, cpu_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int s, r;
        drive_access(4'b0000, 32'h0000_0400, 32'h0, 32'hAAAA_0001, 1, 0, 1'b0, 0, s, r);
        drive_access(4'b0011, 32'h0000_0402, 32'h7777_7777, 32'h0, 0, 1, 1'b0, 1, s, r);
        drive_access(4'b0000, 32'h0000_0408, 32'h0, 32'hAAAA_0003, 0, 0, 1'b1, 0, s, r);
        checks++;
        if (r !== 1 || cpu_rdata !== 32'hAAAA_0003) begin
            errors++;
            $display("FAIL back_to_back got reqs %0d rdata %h want 1 aaaa0003", r, cpu_rdata);
        end
    endtask

    task automatic test_reset_mid();
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0040;
        @(negedge clk);
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (data_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_addr got req %b want 1", data_req);
        end
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        cpu_en = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        rdata_m = 32'h0;
        checks++;
        if (cpu_rdata !== 32'h0 || stall_req !== 1'b0 || data_req !== 1'b0 || data_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_abort got rdata %h stall %b req %b addr %h want all zero",
                     cpu_rdata, stall_req, data_req, data_addr);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        data_data_ok = 1'b1; data_addr_ok = 1'b1; data_rdata = 32'hBADB_AD01;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (cpu_rdata !== rdata_m || stall_req !== 1'b0 || data_req !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_late_ok cycle %0d got rdata %h stall %b req %b want 0 0 0",
                         c, cpu_rdata, stall_req, data_req);
            end
            @(posedge clk); #1;
            data_data_ok = 1'b0; data_addr_ok = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load();
        test_store_byte();
        test_store_sizes();
        test_backpressure();
        test_hold();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got req %0d rd %0d left want 0 0", exp_q.size(), rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port cpu_en  input  1  M-stage instruction is a load or store.
REQ-004 SHALL have port cpu_wen  input  4  M-stage byte write strobes; all-zero means load.
REQ-005 SHALL have port cpu_addr  input  32  M-stage byte address (aluoutM).
REQ-006 SHALL have port cpu_wdata  input  32  M-stage store data, already byte-duplicated.
REQ-007 SHALL have port pipe_stall  input  1  pipeline held by a source other than this block.
REQ-008 SHALL have port cpu_rdata  output  32  load data to the M/W register (readdataM).
REQ-009 SHALL have port stall_req  output  1  request to stall F..M while an access is outstanding.
REQ-010 SHALL have ports data_req out 1, data_wr out 1, data_size out 2, data_addr out 32, data_wdata out 32: SRAM-like request channel.
REQ-011 SHALL have ports data_addr_ok in 1 (request accepted) and data_data_ok in 1 (access complete), plus data_rdata in 32 (valid with data_data_ok).

Function
REQ-012 SHALL implement FSM states IDLE, ADDR, DATA, DONE.
REQ-013 IDLE: cpu_en=1 -> ADDR, latch wr/size/addr/wdata; otherwise stay.
REQ-014 ADDR: data_req=1; addr_ok=1 and data_ok=0 -> DATA; addr_ok=1 and data_ok=1 -> DONE; addr_ok=0 -> stay.
REQ-015 DATA: data_ok=1 -> DONE; otherwise stay; data_req=0.
REQ-016 DONE: pipe_stall=0 -> IDLE; pipe_stall=1 -> stay, holding cpu_rdata.
REQ-017 data_req SHALL be 1 only in ADDR; data_data_ok and data_addr_ok SHALL be ignored in IDLE and DONE.
REQ-018 stall_req SHALL be 1 when (IDLE and cpu_en) or ADDR or DATA; 0 in DONE and otherwise.
REQ-019 Request fields SHALL come from latched registers, stable throughout ADDR.
REQ-020 data_wr SHALL equal OR of cpu_wen at latch time.
REQ-021 Store size: wen 1111 -> 2; 0011 or 1100 -> 1; single-bit wen -> 0; any other non-zero pattern -> 2.
REQ-022 Store data_addr SHALL be cpu_addr unmodified.
REQ-023 Load: data_size=2, data_addr={cpu_addr[31:2],2'b00}; sub-word extension remains in W stage.
REQ-024 cpu_rdata SHALL come from an rdata register loaded with data_rdata on data_ok accepted in ADDR or DATA when data_wr=0; stores leave it unchanged.
REQ-025 Minimum stall for one access with addr_ok in first ADDR cycle and data_ok next cycle: 3 cycles of stall_req (IDLE, ADDR, DATA).
REQ-026 Exactly one request SHALL be issued per M-stage instruction; after DONE->IDLE a new cpu_en starts a new access.
REQ-027 data_wdata SHALL be the latched cpu_wdata; it is a don't-care value for loads but is still driven from the latch.

Reset
REQ-028 rst=0 SHALL force IDLE immediately; data_req=0, stall_req=0 unless cpu_en, cpu_rdata=0, latched fields=0.
REQ-029 Reset mid-access (ADDR or DATA) SHALL abandon the access; a late data_ok after reset release SHALL be ignored in IDLE.

Verification
REQ-030 Load: addr 0x1000_0006, cpu_en=1, wen=0; addr_ok in cycle 2, data_ok+rdata 0xDEADBEEF in cycle 3 -> data_addr 0x1000_0004, size 2, wr 0; stall_req high 3 cycles; cpu_rdata=0xDEADBEEF in DONE.
REQ-031 Store byte: wen 0100, addr 0x20, wdata 0x5A5A5A5A -> data_wr 1, size 0, data_addr 0x20, data_wdata 0x5A5A5A5A; cpu_rdata unchanged.
REQ-032 Backpressure: addr_ok low 4 cycles, then data_ok 2 cycles later -> data_req held exactly while in ADDR; fields stable; stall_req high for 7 cycles total.
REQ-033 Hold: data_ok with rdata 0x12345678 while pipe_stall=1 for 3 cycles -> remains DONE, stall_req 0, cpu_rdata 0x12345678 stable; IDLE after pipe_stall drops.
REQ-034 Same-cycle: addr_ok=1 and data_ok=1 in first ADDR cycle, rdata 0xCAFE0001 -> direct to DONE, stall_req high 2 cycles, cpu_rdata 0xCAFE0001.
REQ-035 Reset in DATA, then data_ok pulse after release -> IDLE, cpu_rdata 0, no spurious DONE or rdata update.
